// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative FIPS-197 AES encryptor, one round per clock through a
// single shared round datapath, with an on-chip key schedule (128/192/256-bit keys).
// Optional CBC chaining is enabled by defining the macro AES_CBC_EN.
module aes_iter_core #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                key_busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        data_out
`ifdef AES_CBC_EN
    ,
    input  logic [127:0]        iv,
    input  logic                iv_load
`endif
);

    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned WW = $clog2(NW);
    localparam int unsigned RW = 4;
    localparam int unsigned KW = 3;

    // Reject unsupported key lengths at elaboration
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

    state_t          st, st_nxt;
    logic [31:0]     w [NW];
    logic            key_ok;
    logic [WW-1:0]   widx;
    logic [KW-1:0]   kmod;
    logic [7:0]      rcon;
    logic [RW-1:0]   rcnt;
    logic [127:0]    blk;
    logic            accept;
    logic [WW-1:0]   rk_idx;
    logic [127:0]    rk, sr, rnd_mid, rnd_last, blk_in;
    logic [31:0]     kw_prev, kw_tmp, kw_new;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s, p;
        s = a;
        p = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]}
                 ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // SubBytes followed by ShiftRows; byte b sits at column b/4, row b%4
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    assign key_busy = (st == KEXP);
    assign in_ready = (st == IDLE) & key_ok & ~key_load;
    assign accept   = in_valid & in_ready;

    // Round key select (key 0 at acceptance) and the shared round datapath
    always_comb begin
        rk_idx   = (st == ROUND) ? WW'({rcnt, 2'b00}) : '0;
        rk       = {w[rk_idx], w[rk_idx + WW'(1)], w[rk_idx + WW'(2)], w[rk_idx + WW'(3)]};
        sr       = sub_shift(blk);
        rnd_mid  = mix_columns(sr) ^ rk;
        rnd_last = sr ^ rk;
    end

    // Next key-schedule word from w[i-1] and w[i-NK]
    always_comb begin
        kw_prev = w[widx - WW'(1)];
        kw_tmp  = kw_prev;
        if (kmod == '0) begin
            kw_tmp = sub_word({kw_prev[23:0], kw_prev[31:24]}) ^ {rcon, 24'h000000};
        end else if (NK > 6 && kmod == KW'(4)) begin
            kw_tmp = sub_word(kw_prev);
        end
        kw_new = w[widx - WW'(NK)] ^ kw_tmp;
    end

`ifdef AES_CBC_EN
    logic [127:0] chain;

    assign blk_in = data_in ^ (iv_load ? iv : chain);

    // Chain register: loaded from iv in IDLE, replaced by each ciphertext
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            chain <= '0;
        end else if (st == IDLE && iv_load) begin
            chain <= iv;
        end else if (st == ROUND && rcnt == RW'(NR)) begin
            chain <= rnd_last;
        end
    end
`else
    assign blk_in = data_in;
`endif

    // State register
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) st <= IDLE;
        else             st <= st_nxt;
    end

    // Next-state logic; key_load wins over a pending block in IDLE
    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (key_load) st_nxt = KEXP;
                     else if (accept) st_nxt = ROUND;
            KEXP:    if (widx == WW'(NW - 1)) st_nxt = IDLE;
            ROUND:   if (rcnt == RW'(NR)) st_nxt = DONE;
            DONE:    if (out_ready) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Control counters, round state and registered outputs
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            key_ok    <= 1'b0;
            widx      <= '0;
            kmod      <= '0;
            rcon      <= 8'h01;
            rcnt      <= '0;
            blk       <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (key_load) begin
                        key_ok <= 1'b0;
                        widx   <= WW'(NK);
                        kmod   <= '0;
                        rcon   <= 8'h01;
                    end else if (accept) begin
                        blk  <= blk_in ^ rk;
                        rcnt <= RW'(1);
                    end
                end
                KEXP: begin
                    widx <= widx + WW'(1);
                    kmod <= (kmod == KW'(NK - 1)) ? '0 : kmod + KW'(1);
                    if (kmod == '0) rcon <= xtime(rcon);
                    if (widx == WW'(NW - 1)) key_ok <= 1'b1;
                end
                ROUND: begin
                    if (rcnt == RW'(NR)) begin
                        data_out  <= rnd_last;
                        out_valid <= 1'b1;
                    end else begin
                        blk  <= rnd_mid;
                        rcnt <= rcnt + RW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rcnt      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key schedule storage: initial key words, then one expanded word per KEXP cycle
    always_ff @(posedge CLK100MHZ) begin
        if (st == IDLE && key_load) begin
            for (int i = 0; i < int'(NK); i++) w[i] <= key_in[KEY_BITS-1-32*i -: 32];
        end else if (st == KEXP) begin
            w[widx] <= kw_new;
        end
    end

endmodule
